// File: rtl/exu_alu_arb.sv
// exu_alu_arb: sequencer and arbiter in front of the shared EXU ALU datapath.
// Two requesters share the datapath:
//   - the ALU issue path (add/lui)
//   - the BJP address adder (always add)
// At most one requester is granted per cycle. The datapath result is captured
// into a single-entry response buffer tagged with its owner, and the buffer is
// returned to that owner over a valid/ready response handshake.
// The BJP requester wins ties, except that after STARVE_MAX consecutive losses
// the ALU requester is force-granted.
module exu_alu_arb #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 3,
  parameter int CNT_W      = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  // ALU request / response
  input  logic            alu_i_valid,
  output logic            alu_i_ready,
  input  logic            alu_i_add,
  input  logic            alu_i_lui,
  input  logic [XLEN-1:0] alu_i_op1,
  input  logic [XLEN-1:0] alu_i_op2,
  output logic            alu_o_valid,
  input  logic            alu_o_ready,
  output logic [XLEN-1:0] alu_o_res,
  // BJP request / response
  input  logic            bjp_i_valid,
  output logic            bjp_i_ready,
  input  logic [XLEN-1:0] bjp_i_op1,
  input  logic [XLEN-1:0] bjp_i_op2,
  output logic            bjp_o_valid,
  input  logic            bjp_o_ready,
  output logic [XLEN-1:0] bjp_o_res,
  // Shared datapath
  output logic            dp_alu_req,
  output logic            dp_alu_add,
  output logic            dp_alu_lui,
  output logic [XLEN-1:0] dp_alu_op1,
  output logic [XLEN-1:0] dp_alu_op2,
  output logic            dp_bjp_req,
  output logic            dp_bjp_add,
  output logic [XLEN-1:0] dp_bjp_op1,
  output logic [XLEN-1:0] dp_bjp_op2,
  input  logic [XLEN-1:0] dp_alu_res,
  input  logic [XLEN-1:0] dp_bjp_res
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  // Response buffer and starvation state
  logic             buf_vld_r;
  logic             buf_own_r;   // 0 = ALU owns the buffer, 1 = BJP owns it
  logic [XLEN-1:0]  buf_res_r;
  logic [CNT_W-1:0] starv_cnt_r;

  // Combinational control
  logic             drain_s;
  logic             can_accept_s;
  logic             grant_alu_s;
  logic             grant_bjp_s;
  logic             buf_vld_nxt_s;
  logic             buf_own_nxt_s;
  logic [XLEN-1:0]  buf_res_nxt_s;
  logic [CNT_W-1:0] starv_cnt_nxt_s;

  // Grant arbitration: only while the buffer is free or being drained this cycle
  always_comb begin
    drain_s      = buf_vld_r & (buf_own_r ? bjp_o_ready : alu_o_ready);
    can_accept_s = ~buf_vld_r | drain_s;
    grant_alu_s  = 1'b0;
    grant_bjp_s  = 1'b0;
    if (rst_n && can_accept_s) begin
      if (alu_i_valid && bjp_i_valid) begin
        if (starv_cnt_r == STARVE_LIM) begin
          grant_alu_s = 1'b1;
        end else begin
          grant_bjp_s = 1'b1;
        end
      end else if (alu_i_valid) begin
        grant_alu_s = 1'b1;
      end else if (bjp_i_valid) begin
        grant_bjp_s = 1'b1;
      end else begin
        grant_alu_s = 1'b0;
        grant_bjp_s = 1'b0;
      end
    end else begin
      grant_alu_s = 1'b0;
      grant_bjp_s = 1'b0;
    end
  end

  // Next state of the response buffer: a grant overwrites, a bare drain empties
  always_comb begin
    buf_vld_nxt_s = buf_vld_r;
    buf_own_nxt_s = buf_own_r;
    buf_res_nxt_s = buf_res_r;
    if (grant_alu_s || grant_bjp_s) begin
      buf_vld_nxt_s = 1'b1;
      buf_own_nxt_s = grant_bjp_s;
      buf_res_nxt_s = grant_alu_s ? dp_alu_res : dp_bjp_res;
    end else if (drain_s) begin
      buf_vld_nxt_s = 1'b0;
    end else begin
      buf_vld_nxt_s = buf_vld_r;
    end
  end

  // Next starvation count: counts ALU losses to BJP, cleared when ALU wins or goes idle
  always_comb begin
    starv_cnt_nxt_s = starv_cnt_r;
    if (grant_alu_s || !alu_i_valid) begin
      starv_cnt_nxt_s = {CNT_W{1'b0}};
    end else if (grant_bjp_s) begin
      if (starv_cnt_r >= STARVE_LIM) begin
        starv_cnt_nxt_s = STARVE_LIM;
      end else begin
        starv_cnt_nxt_s = starv_cnt_r + CNT_ONE;
      end
    end else begin
      starv_cnt_nxt_s = starv_cnt_r;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_vld_r   <= 1'b0;
      buf_own_r   <= 1'b0;
      buf_res_r   <= {XLEN{1'b0}};
      starv_cnt_r <= {CNT_W{1'b0}};
    end else begin
      buf_vld_r   <= buf_vld_nxt_s;
      buf_own_r   <= buf_own_nxt_s;
      buf_res_r   <= buf_res_nxt_s;
      starv_cnt_r <= starv_cnt_nxt_s;
    end
  end

  // Output drive: handshakes and datapath selects, forced low while in reset
  always_comb begin
    alu_i_ready = grant_alu_s;
    bjp_i_ready = grant_bjp_s;
    alu_o_valid = buf_vld_r & ~buf_own_r;
    bjp_o_valid = buf_vld_r & buf_own_r;
    alu_o_res   = buf_res_r;
    bjp_o_res   = buf_res_r;
    dp_alu_req  = grant_alu_s;
    dp_bjp_req  = grant_bjp_s;
    dp_bjp_add  = grant_bjp_s;
    if (rst_n) begin
      dp_alu_add = alu_i_add;
      dp_alu_lui = alu_i_lui;
      dp_alu_op1 = alu_i_op1;
      dp_alu_op2 = alu_i_op2;
      dp_bjp_op1 = bjp_i_op1;
      dp_bjp_op2 = bjp_i_op2;
    end else begin
      dp_alu_add = 1'b0;
      dp_alu_lui = 1'b0;
      dp_alu_op1 = {XLEN{1'b0}};
      dp_alu_op2 = {XLEN{1'b0}};
      dp_bjp_op1 = {XLEN{1'b0}};
      dp_bjp_op2 = {XLEN{1'b0}};
    end
  end

endmodule

// File: tb/tb_exu_alu_arb.sv
// Directed testbench for exu_alu_arb with a behavioural model of the shared datapath.
module tb_exu_alu_arb;

  logic        clk;
  logic        rst_n;
  logic        alu_i_valid, alu_i_ready, alu_i_add, alu_i_lui;
  logic [31:0] alu_i_op1, alu_i_op2;
  logic        alu_o_valid, alu_o_ready;
  logic [31:0] alu_o_res;
  logic        bjp_i_valid, bjp_i_ready;
  logic [31:0] bjp_i_op1, bjp_i_op2;
  logic        bjp_o_valid, bjp_o_ready;
  logic [31:0] bjp_o_res;
  logic        dp_alu_req, dp_alu_add, dp_alu_lui;
  logic [31:0] dp_alu_op1, dp_alu_op2;
  logic        dp_bjp_req, dp_bjp_add;
  logic [31:0] dp_bjp_op1, dp_bjp_op2;
  logic [31:0] dp_alu_res, dp_bjp_res;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  exu_alu_arb #(.XLEN(32), .STARVE_MAX(3), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_i_valid(alu_i_valid), .alu_i_ready(alu_i_ready),
    .alu_i_add(alu_i_add), .alu_i_lui(alu_i_lui),
    .alu_i_op1(alu_i_op1), .alu_i_op2(alu_i_op2),
    .alu_o_valid(alu_o_valid), .alu_o_ready(alu_o_ready), .alu_o_res(alu_o_res),
    .bjp_i_valid(bjp_i_valid), .bjp_i_ready(bjp_i_ready),
    .bjp_i_op1(bjp_i_op1), .bjp_i_op2(bjp_i_op2),
    .bjp_o_valid(bjp_o_valid), .bjp_o_ready(bjp_o_ready), .bjp_o_res(bjp_o_res),
    .dp_alu_req(dp_alu_req), .dp_alu_add(dp_alu_add), .dp_alu_lui(dp_alu_lui),
    .dp_alu_op1(dp_alu_op1), .dp_alu_op2(dp_alu_op2),
    .dp_bjp_req(dp_bjp_req), .dp_bjp_add(dp_bjp_add),
    .dp_bjp_op1(dp_bjp_op1), .dp_bjp_op2(dp_bjp_op2),
    .dp_alu_res(dp_alu_res), .dp_bjp_res(dp_bjp_res)
  );

  // Clock: 10 ns period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Datapath model: add, lui (pass op2), or 0 when neither is selected
  always_comb begin
    if (dp_alu_add) begin
      dp_alu_res = dp_alu_op1 + dp_alu_op2;
    end else if (dp_alu_lui) begin
      dp_alu_res = dp_alu_op2;
    end else begin
      dp_alu_res = 32'd0;
    end
    dp_bjp_res = dp_bjp_add ? (dp_bjp_op1 + dp_bjp_op2) : 32'd0;
  end

  // Overall time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] seq3;
    logic [3:0] seq6;
    seq3 = 8'b1000_1000;
    seq6 = 4'b1000;

    rst_n       = 1'b0;
    alu_i_valid = 1'b1;
    alu_i_add   = 1'b1;
    alu_i_lui   = 1'b0;
    alu_i_op1   = 32'd1;
    alu_i_op2   = 32'd2;
    alu_o_ready = 1'b1;
    bjp_i_valid = 1'b1;
    bjp_i_op1   = 32'd3;
    bjp_i_op2   = 32'd4;
    bjp_o_ready = 1'b1;

    // Reset state: everything low even with both requests valid
    tick;
    tick;
    chk("rst_alu_i_ready", {31'd0, alu_i_ready}, 32'd0);
    chk("rst_bjp_i_ready", {31'd0, bjp_i_ready}, 32'd0);
    chk("rst_alu_o_valid", {31'd0, alu_o_valid}, 32'd0);
    chk("rst_bjp_o_valid", {31'd0, bjp_o_valid}, 32'd0);
    chk("rst_dp_reqs", {30'd0, dp_alu_req, dp_bjp_req}, 32'd0);
    chk("rst_dp_alu_op1", dp_alu_op1, 32'd0);
    alu_i_valid = 1'b0;
    bjp_i_valid = 1'b0;
    rst_n       = 1'b1;
    tick;

    // 1: single ALU add 5+7
    alu_i_valid = 1'b1;
    alu_i_add   = 1'b1;
    alu_i_op1   = 32'd5;
    alu_i_op2   = 32'd7;
    #1;
    chk("t1_alu_i_ready", {31'd0, alu_i_ready}, 32'd1);
    chk("t1_dp_alu_req", {31'd0, dp_alu_req}, 32'd1);
    chk("t1_bjp_i_ready", {31'd0, bjp_i_ready}, 32'd0);
    tick;
    alu_i_valid = 1'b0;
    #1;
    chk("t1_alu_o_valid", {31'd0, alu_o_valid}, 32'd1);
    chk("t1_alu_o_res", alu_o_res, 32'd12);
    chk("t1_bjp_o_valid", {31'd0, bjp_o_valid}, 32'd0);
    tick;
    chk("t1_drained", {31'd0, alu_o_valid}, 32'd0);

    // 2: ALU lui and BJP add together, BJP first
    alu_i_valid = 1'b1;
    alu_i_add   = 1'b0;
    alu_i_lui   = 1'b1;
    alu_i_op1   = 32'h0000_0099;
    alu_i_op2   = 32'h1234_5000;
    bjp_i_valid = 1'b1;
    bjp_i_op1   = 32'h8000_0000;
    bjp_i_op2   = 32'h0000_0010;
    #1;
    chk("t2_bjp_first", {30'd0, alu_i_ready, bjp_i_ready}, 32'd1);
    chk("t2_dp_bjp_add", {31'd0, dp_bjp_add}, 32'd1);
    tick;
    bjp_i_valid = 1'b0;
    #1;
    chk("t2_bjp_o_valid", {31'd0, bjp_o_valid}, 32'd1);
    chk("t2_bjp_o_res", bjp_o_res, 32'h8000_0010);
    chk("t2_alu_i_ready_c1", {31'd0, alu_i_ready}, 32'd1);
    tick;
    alu_i_valid = 1'b0;
    #1;
    chk("t2_alu_o_valid", {31'd0, alu_o_valid}, 32'd1);
    chk("t2_alu_o_res", alu_o_res, 32'h1234_5000);
    chk("t2_bjp_o_valid_c2", {31'd0, bjp_o_valid}, 32'd0);
    tick;

    // 3: both valid continuously, starvation forces every fourth grant to ALU
    alu_i_valid = 1'b1;
    alu_i_add   = 1'b1;
    alu_i_lui   = 1'b0;
    alu_i_op1   = 32'd1;
    alu_i_op2   = 32'd2;
    bjp_i_valid = 1'b1;
    bjp_i_op1   = 32'h100;
    bjp_i_op2   = 32'h4;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_alu_grant_%0d", i), {31'd0, alu_i_ready}, {31'd0, seq3[i]});
      chk($sformatf("t3_bjp_grant_%0d", i), {31'd0, bjp_i_ready}, {31'd0, ~seq3[i]});
      if (i > 0) begin
        chk($sformatf("t3_alu_o_valid_%0d", i), {31'd0, alu_o_valid}, {31'd0, seq3[i-1]});
        chk($sformatf("t3_o_res_%0d", i), alu_o_res, seq3[i-1] ? 32'd3 : 32'h104);
      end
      tick;
    end
    alu_i_valid = 1'b0;
    bjp_i_valid = 1'b0;
    tick;

    // 4: backpressure on a buffered ALU result blocks BJP
    alu_i_valid = 1'b1;
    alu_i_op1   = 32'hFFFF_FFFF;
    alu_i_op2   = 32'd0;
    alu_o_ready = 1'b0;
    #1;
    chk("t4_alu_i_ready", {31'd0, alu_i_ready}, 32'd1);
    tick;
    alu_i_valid = 1'b0;
    bjp_i_valid = 1'b1;
    bjp_i_op1   = 32'h20;
    bjp_i_op2   = 32'h3;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t4_bjp_blocked_%0d", i), {31'd0, bjp_i_ready}, 32'd0);
      chk($sformatf("t4_alu_o_res_%0d", i), alu_o_res, 32'hFFFF_FFFF);
      chk($sformatf("t4_alu_o_valid_%0d", i), {31'd0, alu_o_valid}, 32'd1);
      tick;
    end
    alu_o_ready = 1'b1;
    #1;
    chk("t4_bjp_same_cycle", {31'd0, bjp_i_ready}, 32'd1);
    tick;
    bjp_i_valid = 1'b0;
    #1;
    chk("t4_bjp_o_valid", {31'd0, bjp_o_valid}, 32'd1);
    chk("t4_bjp_o_res", bjp_o_res, 32'h23);
    chk("t4_alu_o_valid_off", {31'd0, alu_o_valid}, 32'd0);
    tick;

    // 5: overflow wrap, signed overflow, and an op with neither add nor lui
    alu_i_valid = 1'b1;
    alu_i_add   = 1'b1;
    alu_i_op1   = 32'hFFFF_FFFF;
    alu_i_op2   = 32'd1;
    #1;
    tick;
    alu_i_op1   = 32'h7FFF_FFFF;
    alu_i_op2   = 32'd1;
    #1;
    chk("t5_wrap_res", alu_o_res, 32'h0000_0000);
    chk("t5_wrap_valid", {31'd0, alu_o_valid}, 32'd1);
    tick;
    alu_i_add   = 1'b0;
    alu_i_lui   = 1'b0;
    alu_i_op1   = 32'd3;
    alu_i_op2   = 32'd4;
    #1;
    chk("t5_ovf_res", alu_o_res, 32'h8000_0000);
    tick;
    alu_i_valid = 1'b0;
    #1;
    chk("t5_noop_res", alu_o_res, 32'h0000_0000);
    chk("t5_noop_valid", {31'd0, alu_o_valid}, 32'd1);
    tick;

    // 6: asynchronous reset with the buffer full and two ALU losses counted
    alu_i_valid = 1'b1;
    alu_i_add   = 1'b1;
    alu_i_op1   = 32'd10;
    alu_i_op2   = 32'd20;
    bjp_i_valid = 1'b1;
    bjp_i_op1   = 32'h40;
    bjp_i_op2   = 32'h2;
    #1;
    tick;
    tick;
    chk("t6_pre_bjp_o_valid", {31'd0, bjp_o_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_alu_i_ready", {31'd0, alu_i_ready}, 32'd0);
    chk("t6_async_bjp_i_ready", {31'd0, bjp_i_ready}, 32'd0);
    chk("t6_async_bjp_o_valid", {31'd0, bjp_o_valid}, 32'd0);
    chk("t6_async_alu_o_valid", {31'd0, alu_o_valid}, 32'd0);
    chk("t6_async_bjp_o_res", bjp_o_res, 32'd0);
    chk("t6_async_dp_reqs", {30'd0, dp_alu_req, dp_bjp_req}, 32'd0);
    tick;
    rst_n = 1'b1;
    #1;
    chk("t6_post_empty", {30'd0, alu_o_valid, bjp_o_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t6_alu_grant_%0d", i), {31'd0, alu_i_ready}, {31'd0, seq6[i]});
      tick;
    end
    alu_i_valid = 1'b0;
    bjp_i_valid = 1'b0;
    tick;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/exu_alu_arb.md
Name: exu_alu_arb

Overview:
- Sequencer and arbiter for the shared EXU ALU datapath.
- Accepts operation requests from two requesters over valid/ready handshakes: the ALU issue path (add/lui) and the BJP (branch/jump) unit's address adder.
- Grants at most one requester per cycle and drives the datapath's one-hot request inputs.
- Captures the datapath result into a single-entry response buffer tagged with its owner, and returns it to that owner over a response handshake.

Parameters:
XLEN, 32, operand/result width; matches the global `XLEN.
STARVE_MAX, 3, consecutive ALU losses to BJP before ALU is force-granted; range 1..15.
CNT_W, 4, starvation counter width; must satisfy 2^CNT_W > STARVE_MAX.

Ports:
clk  in  1  core clock.
rst_n  in  1  asynchronous active-low reset.
alu_i_valid  in  1  ALU request valid.
alu_i_ready  out  1  ALU request accepted this cycle.
alu_i_add  in  1  ALU op is add.
alu_i_lui  in  1  ALU op is lui (pass op2).
alu_i_op1  in  XLEN  ALU operand 1.
alu_i_op2  in  XLEN  ALU operand 2.
alu_o_valid  out  1  ALU response valid.
alu_o_ready  in  1  ALU response consumed.
alu_o_res  out  XLEN  ALU result.
bjp_i_valid  in  1  BJP request valid (always add).
bjp_i_ready  out  1  BJP request accepted.
bjp_i_op1  in  XLEN  BJP operand 1.
bjp_i_op2  in  XLEN  BJP operand 2.
bjp_o_valid  out  1  BJP response valid.
bjp_o_ready  in  1  BJP response consumed.
bjp_o_res  out  XLEN  BJP add result.
dp_alu_req  out  1  datapath ALU-request select.
dp_alu_add  out  1  forwarded alu_i_add.
dp_alu_lui  out  1  forwarded alu_i_lui.
dp_alu_op1  out  XLEN  forwarded alu_i_op1.
dp_alu_op2  out  XLEN  forwarded alu_i_op2.
dp_bjp_req  out  1  datapath BJP-request select.
dp_bjp_add  out  1  constant 1 when dp_bjp_req, else 0.
dp_bjp_op1  out  XLEN  forwarded bjp_i_op1.
dp_bjp_op2  out  XLEN  forwarded bjp_i_op2.
dp_alu_res  in  XLEN  datapath ALU result.
dp_bjp_res  in  XLEN  datapath BJP add result.

Behaviour:
- State: buf_vld (0/1), buf_own (0=ALU, 1=BJP), buf_res[XLEN], starv_cnt[CNT_W].
- Reset (async, rst_n=0): buf_vld=0, buf_own=0, buf_res=0, starv_cnt=0. All outputs 0 while in reset, including i_ready and o_valid.
- drain = buf_vld & (buf_own ? bjp_o_ready : alu_o_ready).
- can_accept = !buf_vld | drain. Buffer empty or draining this cycle gives throughput of 1 op/cycle.
- Arbitration (combinational, only when can_accept):
  - Only one valid: grant it.
  - Both valid: grant BJP unless starv_cnt==STARVE_MAX, in which case grant ALU.
- dp_alu_req=grant_alu, dp_bjp_req=grant_bjp; never both 1. Operand/op outputs are forwarded unconditionally; the datapath masks them.
- alu_i_ready=grant_alu, bjp_i_ready=grant_bjp. A requester's ready is never asserted without its own valid.
- On grant (rising clk): buf_res <= grant_alu ? dp_alu_res : dp_bjp_res; buf_own <= grant_bjp; buf_vld <= 1.
- On drain without grant: buf_vld <= 0. buf_res and buf_own hold.
- Latency: result visible on x_o_res with x_o_valid exactly 1 cycle after the accepting edge.
- alu_o_valid = buf_vld & !buf_own; bjp_o_valid = buf_vld & buf_own. Both o_res outputs = buf_res.
- Backpressure: while the owner's o_ready=0, buf_res is stable, no grants are issued, and starv_cnt holds.
- Starvation counter:
  - +1 (saturating at STARVE_MAX) on a cycle with grant_bjp & alu_i_valid.
  - Cleared on grant_alu, or on any cycle with alu_i_valid=0.
  - Otherwise holds.
- ALU request with both alu_i_add=0 and alu_i_lui=0 is legal; the datapath yields 0 and it is returned as 0.
- Request valids may drop before grant; no state is affected.

Test Plan:
1. Reset, then alu_i_valid=1, add=1, op1=5, op2=7, alu_o_ready=1 -> alu_i_ready=1 at cycle 0; alu_o_valid=1, alu_o_res=12 at cycle 1; bjp_o_valid=0.
2. ALU lui with op2=0x12345000 and BJP add 0x80000000+0x10 both valid at once -> BJP granted first, bjp_o_res=0x80000010 at cycle 1; ALU granted at cycle 1, alu_o_res=0x12345000 at cycle 2.
3. STARVE_MAX=3, both valid continuously, all o_ready=1 -> grant order BJP,BJP,BJP,ALU,BJP,...; starv_cnt returns to 0 after the ALU grant.
4. Backpressure: ALU result 0xFFFFFFFF buffered with alu_o_ready=0 for 4 cycles, BJP valid throughout -> bjp_i_ready=0 and alu_o_res stable for 4 cycles; on alu_o_ready=1, BJP is granted in that same cycle.
5. Overflow: add 0x7FFFFFFF+1 -> res 0x80000000; add 0xFFFFFFFF+1 -> res 0x00000000.
6. Reset mid-operation: assert rst_n=0 with buf_vld=1 and starv_cnt=2 -> all valids/readys 0 immediately (asynchronous); after release, state is empty and starv_cnt=0.
